// File: rtl/y86_pkg.sv
// y86_pkg: shared constants for the Y86-64 fetch-PC generator.
//   - icode values the PC predictor decodes (halt, jXX, call, ret)
//   - state_e: predictor FSM states
package y86_pkg;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with a top pointer.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push          write wdata above the current top
//   pop           discard the top entry (ignored when empty)
//   flush         empty the stack; wins over push/pop; ovf is kept
//   wdata         address to push
//   top           current top entry (undefined contents when count==0)
//   count         number of valid entries, 0..RAS_DEPTH
//   ovf           sticky: a push overwrote the oldest entry
// RAS_DEPTH must be a power of 2 so the pointer wraps by plain overflow.
module ras_stack #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          wdata,
  output logic [ADDR_W-1:0]          top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       ovf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;    // next free slot; top sits just below
  logic [PTR_W-1:0]  top_idx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    top_idx = ptr_q - PTR_W'(1);
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push) begin
      // When full, ptr_q already points at the oldest entry, so the write
      // below overwrites it and the count saturates.
      ptr_d = ptr_q + PTR_W'(1);
      if (count_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop && (count_q != '0)) begin
      ptr_d   = top_idx;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage needs no reset: count gates which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[ptr_q] <= wdata;
    end
  end

  assign top   = mem_q[top_idx];
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: registered fetch-PC generator for the pipelined Y86-64 core.
// Predicts the next PC (jXX taken, call -> valC, ret -> RAS) and applies
// corrections from execute (jXX mispredict) and memory (ret resolution).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   f_valid, stall          fetch has an instruction / pipeline stall
//   f_icode, f_valC, f_valP fetched instruction fields
//   e_mispredict, e_valP    execute jXX resolved not-taken, its fall-through
//   m_ret_valid, m_valM     memory-stage ret and its actual return address
//   m_ret_pred              address that was predicted for that ret
//   pc                      registered fetch PC
//   pred_pc                 combinational prediction for the next fetch
//   redirect                pc was loaded from a correction this cycle
//   fetch_hold              state is RET_WAIT or HALTED
//   ras_count, ras_ovf      RAS occupancy and sticky overflow flag
//
// Handshake: an instruction is consumed at a rising edge exactly when
// f_valid && !stall && state==RUN; a correction input is consumed at every
// edge where it is high, regardless of stall or state.
module pc_predict_unit
  import y86_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       f_valid,
  input  logic                       stall,
  input  logic [3:0]                 f_icode,
  input  logic [ADDR_W-1:0]          f_valC,
  input  logic [ADDR_W-1:0]          f_valP,
  input  logic                       e_mispredict,
  input  logic [ADDR_W-1:0]          e_valP,
  input  logic                       m_ret_valid,
  input  logic [ADDR_W-1:0]          m_valM,
  input  logic [ADDR_W-1:0]          m_ret_pred,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          pred_pc,
  output logic                       redirect,
  output logic                       fetch_hold,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_ovf
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;

  logic              accept;
  logic              m_fix;
  logic              ras_empty;
  logic              ras_push, ras_pop, ras_flush;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] pred_w;

  assign accept    = f_valid && !stall && (state_q == RUN);
  // In RET_WAIT nothing was predicted, so any resolved ret is a fix.
  assign m_fix     = m_ret_valid && ((state_q == RET_WAIT) || (m_valM != m_ret_pred));
  assign ras_empty = (ras_count == '0);

  // Prediction for the instruction currently in fetch. ret with an empty
  // RAS and halt keep the current pc (fetch is held afterwards).
  always_comb begin
    pred_w = f_valP;
    case (f_icode)
      IJXX, ICALL: pred_w = f_valC;
      IRET:        pred_w = ras_empty ? pc_q : ras_top;
      IHALT:       pred_w = pc_q;
      default:     pred_w = f_valP;
    endcase
  end

  // Priority: memory ret fix > execute mispredict > stall > prediction.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ras_flush  = 1'b0;
    if (m_fix) begin
      pc_d       = m_valM;
      state_d    = RUN;
      redirect_d = 1'b1;
      ras_flush  = 1'b1;
    end else if (e_mispredict) begin
      pc_d       = e_valP;
      state_d    = RUN;
      redirect_d = 1'b1;
    end else if (accept) begin
      pc_d = pred_w;
      case (f_icode)
        ICALL: ras_push = 1'b1;
        IRET: begin
          if (ras_empty) state_d = RET_WAIT;
          else           ras_pop = 1'b1;
        end
        IHALT:   state_d = HALTED;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .rst_n(rst_n),
    .push (ras_push),
    .pop  (ras_pop),
    .flush(ras_flush),
    .wdata(f_valP),
    .top  (ras_top),
    .count(ras_count),
    .ovf  (ras_ovf)
  );

  assign pc         = pc_q;
  assign pred_pc    = pred_w;
  assign redirect   = redirect_q;
  assign fetch_hold = (state_q != RUN);

endmodule
